// File: rtl/fighter_action_sequencer.sv
// fighter_action_sequencer
// Per-player move controller: turns punch/kick/block buttons into timed
// attack sequences driven by an external fractional-second timer.
//
// Timer handshake (valid/ready): timer_start is the request and stays high
// while the FSM is in START or COOL_START; timer_running is the acknowledge.
// The request drops on the same edge that samples timer_running=1. If no
// acknowledge arrives within ACK_TIMEOUT cycles, the request is withdrawn and
// timer_err latches until reset.
//
// All outputs are flops loaded from the next-state decode, so they change
// together with the state register and clear asynchronously on reset.

module fighter_action_sequencer #(
    parameter int PUNCH_FRAC  = 4,
    parameter int KICK_FRAC   = 2,
    parameter int COOL_FRAC   = 8,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_punch,
    input  logic       btn_kick,
    input  logic       btn_block,
    input  logic       timer_running,
    input  logic       timer_halfway,
    input  logic       timer_done,
    output logic       timer_start,
    output logic [3:0] timer_fraction,
    output logic [1:0] action,
    output logic       hit_active,
    output logic       block_active,
    output logic       busy,
    output logic       timer_err,
    output logic [7:0] hit_count
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [1:0] ACT_NONE  = 2'd0;
    localparam logic [1:0] ACT_PUNCH = 2'd1;
    localparam logic [1:0] ACT_KICK  = 2'd2;
    localparam logic [1:0] ACT_BLOCK = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WINDUP,
        S_STRIKE,
        S_COOL_START,
        S_COOL,
        S_BLOCK
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [1:0] move_q;
    logic [1:0] move_n;
    logic       punch_prev;
    logic       kick_prev;
    logic [CNT_W-1:0] ack_cnt;

    logic punch_rise;
    logic kick_rise;
    logic in_handshake;
    logic ack_expired;

    // Output next values, decoded from the next state
    logic       timer_start_d;
    logic [3:0] timer_fraction_d;
    logic [1:0] action_d;
    logic       hit_active_d;
    logic       block_active_d;
    logic       busy_d;

    assign punch_rise   = btn_punch & ~punch_prev;
    assign kick_rise    = btn_kick & ~kick_prev;
    assign in_handshake = (state == S_START) || (state == S_COOL_START);
    assign ack_expired  = in_handshake && !timer_running &&
                          (ack_cnt == CNT_W'(ACK_TIMEOUT - 1));

    // State register plus the bookkeeping that advances with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            move_q     <= ACT_NONE;
            // Previous values start high so a button held through reset
            // release is not seen as a fresh press.
            punch_prev <= 1'b1;
            kick_prev  <= 1'b1;
            ack_cnt    <= '0;
            timer_err  <= 1'b0;
            hit_count  <= 8'd0;
        end else begin
            state      <= state_n;
            move_q     <= move_n;
            punch_prev <= btn_punch;
            kick_prev  <= btn_kick;
            // Counter sits at zero outside the handshakes, so it is clear
            // on entry to START/COOL_START.
            if (in_handshake) begin
                ack_cnt <= ack_cnt + CNT_W'(1);
            end else begin
                ack_cnt <= '0;
            end
            if (ack_expired) begin
                timer_err <= 1'b1;
            end
            if (state == S_STRIKE && timer_done && hit_count != 8'hFF) begin
                hit_count <= hit_count + 8'd1;
            end
        end
    end

    // Next-state logic; move_n remembers which attack is in flight
    always_comb begin
        state_n = state;
        move_n  = move_q;
        case (state)
            S_IDLE: begin
                if (btn_block) begin
                    state_n = S_BLOCK;
                end else if (kick_rise) begin
                    state_n = S_START;
                    move_n  = ACT_KICK;
                end else if (punch_rise) begin
                    state_n = S_START;
                    move_n  = ACT_PUNCH;
                end
            end
            S_START: begin
                if (timer_running) begin
                    state_n = S_WINDUP;
                end else if (ack_expired) begin
                    state_n = S_IDLE;
                    move_n  = ACT_NONE;
                end
            end
            S_WINDUP: begin
                // A done without a halfway skips the hit window entirely
                if (timer_done) begin
                    state_n = S_COOL_START;
                end else if (timer_halfway) begin
                    state_n = S_STRIKE;
                end
            end
            S_STRIKE: begin
                if (timer_done) begin
                    state_n = S_COOL_START;
                end
            end
            S_COOL_START: begin
                if (timer_running) begin
                    state_n = S_COOL;
                end else if (ack_expired) begin
                    state_n = S_IDLE;
                    move_n  = ACT_NONE;
                end
            end
            S_COOL: begin
                if (timer_done) begin
                    state_n = S_IDLE;
                    move_n  = ACT_NONE;
                end
            end
            S_BLOCK: begin
                if (!btn_block) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
                move_n  = ACT_NONE;
            end
        endcase
    end

    // Output decode from the next state and next move
    always_comb begin
        timer_start_d    = (state_n == S_START) || (state_n == S_COOL_START);
        hit_active_d     = (state_n == S_STRIKE);
        block_active_d   = (state_n == S_BLOCK);
        busy_d           = (state_n != S_IDLE);
        timer_fraction_d = 4'd0;
        action_d         = move_n;
        case (state_n)
            S_START, S_WINDUP, S_STRIKE: begin
                timer_fraction_d = (move_n == ACT_KICK) ? 4'(KICK_FRAC)
                                                        : 4'(PUNCH_FRAC);
            end
            S_COOL_START, S_COOL: begin
                timer_fraction_d = 4'(COOL_FRAC);
            end
            S_BLOCK: begin
                action_d = ACT_BLOCK;
            end
            S_IDLE: begin
                action_d = ACT_NONE;
            end
            default: begin
                timer_fraction_d = 4'd0;
            end
        endcase
    end

    // Output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_start    <= 1'b0;
            timer_fraction <= 4'd0;
            action         <= ACT_NONE;
            hit_active     <= 1'b0;
            block_active   <= 1'b0;
            busy           <= 1'b0;
        end else begin
            timer_start    <= timer_start_d;
            timer_fraction <= timer_fraction_d;
            action         <= action_d;
            hit_active     <= hit_active_d;
            block_active   <= block_active_d;
            busy           <= busy_d;
        end
    end

endmodule

// File: tb/tb_fighter_action_sequencer.sv
// Directed testbench for fighter_action_sequencer. The timer is emulated by
// driver tasks that raise timer_running one cycle after a start request and
// emit halfway/done pulses on demand.

module tb_fighter_action_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_punch = 1'b0;
    logic       btn_kick = 1'b0;
    logic       btn_block = 1'b0;
    logic       timer_running = 1'b0;
    logic       timer_halfway = 1'b0;
    logic       timer_done = 1'b0;
    logic       timer_start;
    logic [3:0] timer_fraction;
    logic [1:0] action;
    logic       hit_active;
    logic       block_active;
    logic       busy;
    logic       timer_err;
    logic [7:0] hit_count;

    int checks = 0;
    int failures = 0;
    int exp_hits = 0;

    fighter_action_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .btn_punch      (btn_punch),
        .btn_kick       (btn_kick),
        .btn_block      (btn_block),
        .timer_running  (timer_running),
        .timer_halfway  (timer_halfway),
        .timer_done     (timer_done),
        .timer_start    (timer_start),
        .timer_fraction (timer_fraction),
        .action         (action),
        .hit_active     (hit_active),
        .block_active   (block_active),
        .busy           (busy),
        .timer_err      (timer_err),
        .hit_count      (hit_count)
    );

    // Clock: 100 MHz
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_punch();
        btn_punch = 1'b1;
        tick();
        btn_punch = 1'b0;
    endtask

    // Called with the DUT already in START/COOL_START; acks one cycle later
    task automatic ack_start();
        tick();
        timer_running = 1'b1;
        tick();
    endtask

    task automatic pulse_half();
        timer_halfway = 1'b1;
        tick();
        timer_halfway = 1'b0;
    endtask

    task automatic pulse_done();
        timer_done    = 1'b1;
        timer_running = 1'b0;
        tick();
        timer_done    = 1'b0;
    endtask

    task automatic punch_sequence();
        press_punch();
        ack_start();
        tick();
        pulse_half();
        pulse_done();
        ack_start();
        pulse_done();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        #2;
        checks++;
        if ({timer_start, hit_active, block_active, busy, timer_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {timer_start, hit_active, block_active, busy, timer_err});
        end
        checks++;
        if ({action, timer_fraction, hit_count} !== 14'd0) begin
            failures++;
            $display("FAIL reset_values got action=%0d frac=%0d hits=%0d exp=0/0/0",
                     action, timer_fraction, hit_count);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_punch();
        press_punch();
        checks++;
        if (timer_start !== 1'b1 || timer_fraction !== 4'd4 || action !== 2'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL punch_start got start=%b frac=%0d act=%0d busy=%b exp=1/4/1/1",
                     timer_start, timer_fraction, action, busy);
        end
        tick();
        checks++;
        if (timer_start !== 1'b1) begin
            failures++;
            $display("FAIL punch_start_cycle2 got=%b exp=1", timer_start);
        end
        timer_running = 1'b1;
        tick();
        checks++;
        if (timer_start !== 1'b0 || timer_fraction !== 4'd4 || hit_active !== 1'b0) begin
            failures++;
            $display("FAIL punch_windup got start=%b frac=%0d hit=%b exp=0/4/0",
                     timer_start, timer_fraction, hit_active);
        end
        tick();
        pulse_half();
        checks++;
        if (hit_active !== 1'b1 || action !== 2'd1) begin
            failures++;
            $display("FAIL punch_strike got hit=%b act=%0d exp=1/1", hit_active, action);
        end
        tick();
        checks++;
        if (hit_active !== 1'b1) begin
            failures++;
            $display("FAIL punch_strike_hold got hit=%b exp=1", hit_active);
        end
        pulse_done();
        exp_hits++;
        checks++;
        if (hit_active !== 1'b0 || timer_start !== 1'b1 || timer_fraction !== 4'd8 ||
            action !== 2'd1 || hit_count !== 8'(exp_hits)) begin
            failures++;
            $display("FAIL punch_cool_start got hit=%b start=%b frac=%0d act=%0d hits=%0d exp=0/1/8/1/%0d",
                     hit_active, timer_start, timer_fraction, action, hit_count, exp_hits);
        end
        ack_start();
        checks++;
        if (timer_start !== 1'b0 || timer_fraction !== 4'd8 || busy !== 1'b1) begin
            failures++;
            $display("FAIL punch_cool got start=%b frac=%0d busy=%b exp=0/8/1",
                     timer_start, timer_fraction, busy);
        end
        pulse_half();
        checks++;
        if (hit_active !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL cool_halfway_ignored got hit=%b busy=%b exp=0/1", hit_active, busy);
        end
        pulse_done();
        checks++;
        if (busy !== 1'b0 || action !== 2'd0 || hit_count !== 8'(exp_hits)) begin
            failures++;
            $display("FAIL punch_end got busy=%b act=%0d hits=%0d exp=0/0/%0d",
                     busy, action, hit_count, exp_hits);
        end
    endtask

    task automatic test_back_to_back();
        // Punch edge on the very first IDLE cycle after the cooldown ends
        punch_sequence();
        exp_hits++;
        press_punch();
        checks++;
        if (timer_start !== 1'b1 || action !== 2'd1) begin
            failures++;
            $display("FAIL back_to_back got start=%b act=%0d exp=1/1", timer_start, action);
        end
        ack_start();
        tick();
        pulse_half();
        pulse_done();
        exp_hits++;
        ack_start();
        pulse_done();
        checks++;
        if (hit_count !== 8'(exp_hits) || busy !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back_end got hits=%0d busy=%b exp=%0d/0", hit_count, busy, exp_hits);
        end
    endtask

    task automatic test_simultaneous();
        btn_punch = 1'b1;
        btn_kick  = 1'b1;
        tick();
        btn_punch = 1'b0;
        btn_kick  = 1'b0;
        checks++;
        if (action !== 2'd2 || timer_fraction !== 4'd2 || timer_start !== 1'b1) begin
            failures++;
            $display("FAIL kick_priority got act=%0d frac=%0d start=%b exp=2/2/1",
                     action, timer_fraction, timer_start);
        end
        ack_start();
        // Early done: no halfway pulse, so no hit window and no count
        pulse_done();
        checks++;
        if (hit_active !== 1'b0 || hit_count !== 8'(exp_hits) || timer_fraction !== 4'd8 ||
            action !== 2'd2) begin
            failures++;
            $display("FAIL early_done got hit=%b hits=%0d frac=%0d act=%0d exp=0/%0d/8/2",
                     hit_active, hit_count, timer_fraction, action, exp_hits);
        end
        ack_start();
        pulse_done();
        btn_block = 1'b1;
        btn_punch = 1'b1;
        btn_kick  = 1'b1;
        tick();
        checks++;
        if (action !== 2'd3 || block_active !== 1'b1 || timer_start !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL block_priority got act=%0d blk=%b start=%b busy=%b exp=3/1/0/1",
                     action, block_active, timer_start, busy);
        end
        tick();
        checks++;
        if (block_active !== 1'b1 || timer_start !== 1'b0) begin
            failures++;
            $display("FAIL block_hold got blk=%b start=%b exp=1/0", block_active, timer_start);
        end
        btn_block = 1'b0;
        btn_punch = 1'b0;
        btn_kick  = 1'b0;
        tick();
        checks++;
        if (block_active !== 1'b0 || busy !== 1'b0 || action !== 2'd0) begin
            failures++;
            $display("FAIL block_release got blk=%b busy=%b act=%0d exp=0/0/0",
                     block_active, busy, action);
        end
    endtask

    task automatic test_busy_presses();
        press_punch();
        ack_start();
        pulse_half();
        // Punch during STRIKE
        btn_punch = 1'b1;
        tick();
        btn_punch = 1'b0;
        tick();
        pulse_done();
        exp_hits++;
        ack_start();
        // Punch during COOL, then block held through the rest of COOL
        btn_punch = 1'b1;
        tick();
        btn_punch = 1'b0;
        btn_block = 1'b1;
        tick();
        pulse_done();
        checks++;
        if (busy !== 1'b0 || hit_count !== 8'(exp_hits)) begin
            failures++;
            $display("FAIL busy_drop_idle got busy=%b hits=%0d exp=0/%0d", busy, hit_count, exp_hits);
        end
        tick();
        checks++;
        if (block_active !== 1'b1 || action !== 2'd3 || busy !== 1'b1) begin
            failures++;
            $display("FAIL block_after_cool got blk=%b act=%0d busy=%b exp=1/3/1",
                     block_active, action, busy);
        end
        btn_block = 1'b0;
        tick();
        tick();
        checks++;
        if (timer_start !== 1'b0 || busy !== 1'b0 || hit_count !== 8'(exp_hits)) begin
            failures++;
            $display("FAIL press_not_queued got start=%b busy=%b hits=%0d exp=0/0/%0d",
                     timer_start, busy, hit_count, exp_hits);
        end
    endtask

    task automatic test_timeout();
        press_punch();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (timer_start !== 1'b1 || timer_err !== 1'b0) begin
                failures++;
                $display("FAIL timeout_wait_%0d got start=%b err=%b exp=1/0", i, timer_start, timer_err);
            end
        end
        tick();
        checks++;
        if (timer_err !== 1'b1 || timer_start !== 1'b0 || action !== 2'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout got err=%b start=%b act=%0d busy=%b exp=1/0/0/0",
                     timer_err, timer_start, action, busy);
        end
        tick();
        tick();
        checks++;
        if (timer_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky got=%b exp=1", timer_err);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 260; i++) begin
            punch_sequence();
            if (exp_hits < 255) exp_hits++;
        end
        checks++;
        if (hit_count !== 8'd255 || exp_hits != 255) begin
            failures++;
            $display("FAIL saturation got hits=%0d exp=255", hit_count);
        end
    endtask

    task automatic test_reset_mid_strike();
        press_punch();
        ack_start();
        pulse_half();
        checks++;
        if (hit_active !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_strike got hit=%b exp=1", hit_active);
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({timer_start, hit_active, block_active, busy, timer_err, action, timer_fraction, hit_count} !== 19'd0) begin
            failures++;
            $display("FAIL async_reset got start=%b hit=%b blk=%b busy=%b err=%b act=%0d frac=%0d hits=%0d exp=all 0",
                     timer_start, hit_active, block_active, busy, timer_err, action, timer_fraction, hit_count);
        end
        timer_running = 1'b0;
        btn_punch     = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (timer_start !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL held_punch_after_reset_%0d got start=%b busy=%b exp=0/0", i, timer_start, busy);
            end
        end
        btn_punch = 1'b0;
    endtask

    // Global time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_punch();
        test_back_to_back();
        test_simultaneous();
        test_busy_presses();
        test_timeout();
        test_saturation();
        test_reset_mid_strike();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fighter_action_sequencer.md
# fighter_action_sequencer

Per-player move controller sitting directly upstream of the fractional-second timer. Converts debounced punch/kick/block buttons into timed attack sequences: it launches the timer with a move-specific fraction, uses the timer's halfway pulse to open the hit window, and uses the done pulse to run a recovery cooldown. Its outputs drive the hit detector and the sprite selector.

## Interface

- `PUNCH_FRAC`, default 4: timer fraction for a punch (¼ s).
- `KICK_FRAC`, default 2: timer fraction for a kick (½ s).
- `COOL_FRAC`, default 8: timer fraction for post-attack cooldown (⅛ s).
- `ACK_TIMEOUT`, default 4: cycles to wait for `timer_running` after a start request.

Ports:

- `clk` in 1: system clock (100 MHz).
- `reset` in 1: asynchronous, active-low reset.
- `btn_punch` in 1: debounced, synchronized punch button (level).
- `btn_kick` in 1: debounced, synchronized kick button (level).
- `btn_block` in 1: debounced, synchronized block button (level).
- `timer_running` in 1: timer busy flag.
- `timer_halfway` in 1: timer one-cycle halfway pulse.
- `timer_done` in 1: timer one-cycle completion pulse.
- `timer_start` out 1: start request to the timer.
- `timer_fraction` out 4: fraction to the timer.
- `action` out 2: 0 none, 1 punch, 2 kick, 3 block.
- `hit_active` out 1: damage window open.
- `block_active` out 1: guarding.
- `busy` out 1: high in every state except IDLE.
- `timer_err` out 1: sticky flag set on timer acknowledge timeout.
- `hit_count` out 8: completed strikes, saturating at 255.

## Operation

- **Edge detect.**
  - Punch and kick trigger on rising edges only.
  - The previous-value registers reset to 1, so a button held through reset release does not trigger.
  - Block is level-sensitive.
- **States:** IDLE, START, WINDUP, STRIKE, COOL_START, COOL, BLOCK.
- **IDLE.**
  - Priority is block level > kick edge > punch edge.
  - Block → BLOCK.
  - Kick → START, with `action`=2 and `timer_fraction`=KICK_FRAC.
  - Punch → START, with `action`=1 and `timer_fraction`=PUNCH_FRAC.
- **START.**
  - Hold `timer_start`=1 until `timer_running`=1 is sampled, then → WINDUP. `timer_start` drops the same edge.
  - If `timer_running` is not seen within ACK_TIMEOUT cycles of entering START: set `timer_err`, then → IDLE with `action`=0.
- **WINDUP.**
  - `timer_halfway` → STRIKE.
  - `timer_done` without a prior halfway → COOL_START. No hit window opens and `hit_count` is unchanged.
- **STRIKE.**
  - `hit_active`=1.
  - On `timer_done` → COOL_START and increment `hit_count` (saturating).
- **COOL_START.**
  - `timer_fraction`=COOL_FRAC and `action` keeps the move value.
  - Uses the same start handshake and timeout as START; on acknowledge → COOL.
- **COOL.**
  - On `timer_done` → IDLE with `action`=0.
  - `timer_halfway` is ignored.
- **BLOCK.**
  - `block_active`=1 and `action`=3.
  - On `btn_block`=0 → IDLE. No timer is used.
- **Button handling while busy.**
  - Punch/kick edges in any non-IDLE state are dropped, not queued.
  - Block held through a cooldown enters BLOCK on the first IDLE cycle.
- **Output stability.** `timer_fraction` is constant from START/COOL_START entry until that timer's `timer_done`.

## Timing

- **Reset.** Asserting `reset` low immediately forces:
  - state IDLE;
  - `timer_start`, `hit_active`, `block_active`, `busy`, `timer_err` = 0;
  - `action`=0, `timer_fraction`=0, `hit_count`=0.
- **Mid-sequence reset.** Reset mid-sequence abandons the sequence. The timer is reset by the same net.
- **Outputs.** All outputs are registered and decode from state.
- **Button to start latency.** Button edge at cycle N (sampled) → IDLE decodes at N+1 → `timer_start`=1 from N+1.
- **Start handshake.**
  - With the timer acknowledging one cycle later, `timer_start` is high for exactly 2 cycles.
  - START exit occurs on the edge that samples `timer_running`=1.
- **Hit window.**
  - `hit_active` rises 1 cycle after the `timer_halfway` pulse.
  - `hit_active` falls 1 cycle after the `timer_done` pulse.
- **End of sequence.** `busy` falls 1 cycle after the COOL `timer_done`. A new punch edge is accepted that same cycle.
- **Timeout counter.**
  - Width is clog2(ACK_TIMEOUT+1).
  - Cleared on entry to START/COOL_START.

## Test plan

- **Punch.** Reset, then punch edge with a timer model (1-cycle ack).
  - `timer_fraction`=4 and `timer_start` high for 2 cycles.
  - `hit_active` high from halfway+1 to done+1.
  - Cooldown runs with fraction 8, then `hit_count`=1 and `busy`=0.
- **Simultaneous press.** Punch and kick rising in the same cycle → `action`=2, `timer_fraction`=2. Block held at the same time instead → `action`=3, `block_active`=1, and no `timer_start`.
- **Presses while busy.**
  - Punch edge during STRIKE and during COOL is dropped: `hit_count` increments once.
  - Block held through COOL → BLOCK one cycle after `busy` falls.
- **Ack timeout.** The timer never asserts `timer_running` → after 4 cycles `timer_err`=1, `timer_start`=0, `action`=0, IDLE.
- **Reset behaviour.**
  - Reset pulled low during STRIKE → all outputs 0 asynchronously.
  - After release, a still-held `btn_punch` produces no new attack.
- **Saturation and early done.**
  - 256 completed strikes → `hit_count` stays 255.
  - `timer_done` without halfway → no `hit_active`, and the count is unchanged.
